rs_slot_alloc: RTL and testbench

Dual-port slot allocator for the 32-entry reservation station. It keeps a registered busy vector and finds free slots by priority-encoding the inverted vector: the lowest free index goes to port 0 and the highest free index goes to port 1. Dispatch receives up to two slot grants per cycle, and issue/squash returns up to two slots per cycle. It sits between dispatch (upstream) and the RS entry array (downstream).

---
 rtl/rs_slot_alloc.sv | 109 ++++++++++
 tb/tb_rs_slot_alloc.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/rs_slot_alloc.sv
// Dual-port slot allocator for the 32-entry reservation station.
// Port 0 is granted the lowest free slot and port 1 the highest; releases return slots.
module rs_slot_alloc #(
  parameter int unsigned NUM_ENTRIES = 32,
  parameter int unsigned IDX_W       = 5
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [1:0]             alloc_req,
  output logic [1:0]             grant_valid,
  output logic [IDX_W-1:0]       grant_idx0,
  output logic [IDX_W-1:0]       grant_idx1,
  input  logic [1:0]             free_en,
  input  logic [IDX_W-1:0]       free_idx0,
  input  logic [IDX_W-1:0]       free_idx1,
  input  logic                   flush,
  output logic [NUM_ENTRIES-1:0] busy,
  output logic [5:0]             free_cnt,
  output logic [1:0]             avail_cnt,
  output logic                   err
);

  logic [NUM_ENTRIES-1:0] r_busy;
  logic [5:0]             r_free_cnt;
  logic                   r_err;

  logic [NUM_ENTRIES-1:0] w_fv;
  logic [IDX_W-1:0]       w_lo;
  logic [IDX_W-1:0]       w_hi;
  logic [1:0]             w_gv;
  logic [NUM_ENTRIES-1:0] w_gmask;
  logic [NUM_ENTRIES-1:0] w_rmask;
  logic                   w_rel0;
  logic                   w_rel1;
  logic                   w_same;
  logic                   w_err_evt;
  logic [NUM_ENTRIES-1:0] w_busy_d;
  logic [5:0]             w_cnt_d;

  assign w_fv = ~r_busy;

  // Lowest and highest free index; both stay 0 when nothing is free.
  always_comb begin
    w_lo = '0;
    w_hi = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (w_fv[i]) w_lo = IDX_W'(i);
    end
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (w_fv[i]) w_hi = IDX_W'(i);
    end
  end

  always_comb begin
    w_gv = 2'b00;
    if (r_free_cnt >= 6'd2) begin
      w_gv = alloc_req;
    end else if (r_free_cnt == 6'd1) begin
      w_gv[0] = alloc_req[0];
      w_gv[1] = alloc_req[1] & ~alloc_req[0];
    end
  end

  // A release is effective only on a busy slot; a duplicate index counts once.
  assign w_same    = free_en[0] & free_en[1] & (free_idx0 == free_idx1);
  assign w_rel0    = free_en[0] & r_busy[free_idx0];
  assign w_rel1    = free_en[1] & r_busy[free_idx1] & ~w_same;
  assign w_err_evt = (free_en[0] & ~r_busy[free_idx0]) | (free_en[1] & ~r_busy[free_idx1]) |
                     w_same;

  always_comb begin
    w_gmask = '0;
    w_rmask = '0;
    if (w_gv[0]) w_gmask[w_lo] = 1'b1;
    if (w_gv[1]) w_gmask[w_hi] = 1'b1;
    if (w_rel0)  w_rmask[free_idx0] = 1'b1;
    if (w_rel1)  w_rmask[free_idx1] = 1'b1;
  end

  assign w_busy_d = (r_busy & ~w_rmask) | w_gmask;
  assign w_cnt_d  = r_free_cnt + {5'd0, w_rel0} + {5'd0, w_rel1}
                    - {5'd0, w_gv[0]} - {5'd0, w_gv[1]};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_busy     <= '0;
      r_free_cnt <= 6'd32;
      r_err      <= 1'b0;
    end else begin
      r_err <= r_err | w_err_evt;
      if (flush) begin
        r_busy     <= '0;
        r_free_cnt <= 6'd32;
      end else begin
        r_busy     <= w_busy_d;
        r_free_cnt <= w_cnt_d;
      end
    end
  end

  assign grant_valid = w_gv;
  assign grant_idx0  = w_lo;
  assign grant_idx1  = w_hi;
  assign busy        = r_busy;
  assign free_cnt    = r_free_cnt;
  assign avail_cnt   = (r_free_cnt >= 6'd2) ? 2'd2 : r_free_cnt[1:0];
  assign err         = r_err;

endmodule

// File: tb/tb_rs_slot_alloc.sv
// Directed self-checking bench for rs_slot_alloc.
module tb_rs_slot_alloc;

  logic        clock;
  logic        reset;
  logic [1:0]  alloc_req;
  logic [1:0]  grant_valid;
  logic [4:0]  grant_idx0;
  logic [4:0]  grant_idx1;
  logic [1:0]  free_en;
  logic [4:0]  free_idx0;
  logic [4:0]  free_idx1;
  logic        flush;
  logic [31:0] busy;
  logic [5:0]  free_cnt;
  logic [1:0]  avail_cnt;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;

  rs_slot_alloc #(.NUM_ENTRIES(32), .IDX_W(5)) dut (
    .clock       (clock),
    .reset       (reset),
    .alloc_req   (alloc_req),
    .grant_valid (grant_valid),
    .grant_idx0  (grant_idx0),
    .grant_idx1  (grant_idx1),
    .free_en     (free_en),
    .free_idx0   (free_idx0),
    .free_idx1   (free_idx1),
    .flush       (flush),
    .busy        (busy),
    .free_cnt    (free_cnt),
    .avail_cnt   (avail_cnt),
    .err         (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Count must stay within 0..32 at every sampling point.
  always @(negedge clock) begin
    if (reset) chk("cnt_range", 32'(free_cnt <= 6'd32), 32'd1);
  end

  initial begin
    reset = 1'b0; alloc_req = 2'b00; free_en = 2'b00;
    free_idx0 = '0; free_idx1 = '0; flush = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    #1;
    chk("rst_busy", busy, 32'h0);
    chk("rst_cnt", 32'(free_cnt), 32'd32);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_avail", 32'(avail_cnt), 32'd2);
    chk("rst_idx0", 32'(grant_idx0), 32'd0);
    chk("rst_idx1", 32'(grant_idx1), 32'd31);
    chk("rst_gv", 32'(grant_valid), 32'd0);

    // First dual grant
    step();
    alloc_req = 2'b11;
    #1;
    chk("g1_gv", 32'(grant_valid), 32'd3);
    chk("g1_idx0", 32'(grant_idx0), 32'd0);
    chk("g1_idx1", 32'(grant_idx1), 32'd31);
    step();
    chk("g1_busy", busy, 32'h8000_0001);
    chk("g1_cnt", 32'(free_cnt), 32'd30);
    chk("g2_idx0", 32'(grant_idx0), 32'd1);
    chk("g2_idx1", 32'(grant_idx1), 32'd30);

    // 15 more dual grants fill the station
    repeat (15) step();
    chk("full_cnt", 32'(free_cnt), 32'd0);
    chk("full_busy", busy, 32'hFFFF_FFFF);
    chk("full_gv", 32'(grant_valid), 32'd0);
    chk("full_avail", 32'(avail_cnt), 32'd0);
    chk("full_idx0", 32'(grant_idx0), 32'd0);
    step();
    chk("full_hold_busy", busy, 32'hFFFF_FFFF);
    chk("full_hold_cnt", 32'(free_cnt), 32'd0);

    // Single free slot 7
    alloc_req = 2'b00; free_en = 2'b01; free_idx0 = 5'd7;
    step();
    free_en = 2'b00;
    chk("one_busy", busy, 32'hFFFF_FF7F);
    chk("one_cnt", 32'(free_cnt), 32'd1);
    chk("one_avail", 32'(avail_cnt), 32'd1);
    alloc_req = 2'b11;
    #1;
    chk("one_gv11", 32'(grant_valid), 32'd1);
    chk("one_idx0", 32'(grant_idx0), 32'd7);
    alloc_req = 2'b10;
    #1;
    chk("one_gv10", 32'(grant_valid), 32'd2);
    chk("one_idx1", 32'(grant_idx1), 32'd7);
    step();
    chk("one_taken_cnt", 32'(free_cnt), 32'd0);
    chk("one_taken_busy", busy, 32'hFFFF_FFFF);

    // Release 3 and 20 while full, alongside requests
    alloc_req = 2'b11; free_en = 2'b11; free_idx0 = 5'd3; free_idx1 = 5'd20;
    #1;
    chk("rel_gv", 32'(grant_valid), 32'd0);
    step();
    free_en = 2'b00;
    #1;
    chk("rel_cnt", 32'(free_cnt), 32'd2);
    chk("rel_gv2", 32'(grant_valid), 32'd3);
    chk("rel_idx0", 32'(grant_idx0), 32'd3);
    chk("rel_idx1", 32'(grant_idx1), 32'd20);
    step();
    alloc_req = 2'b00;
    chk("rel_refill", 32'(free_cnt), 32'd0);

    // Error cases
    free_en = 2'b01; free_idx0 = 5'd5;
    step();
    chk("e_free5_cnt", 32'(free_cnt), 32'd1);
    chk("e_free5_err", 32'(err), 32'd0);
    step();
    free_en = 2'b00;
    chk("e_dbl_err", 32'(err), 32'd1);
    chk("e_dbl_cnt", 32'(free_cnt), 32'd1);
    chk("e_dbl_busy", busy, 32'hFFFF_FFDF);
    free_en = 2'b11; free_idx0 = 5'd9; free_idx1 = 5'd9;
    step();
    free_en = 2'b00;
    chk("e_same_cnt", 32'(free_cnt), 32'd2);
    chk("e_same_busy", busy, 32'hFFFF_FDDF);
    chk("e_same_err", 32'(err), 32'd1);

    // Flush overrides grant and release
    flush = 1'b1; alloc_req = 2'b11; free_en = 2'b01; free_idx0 = 5'd0;
    #1;
    chk("fl_gv", 32'(grant_valid), 32'd3);
    step();
    flush = 1'b0; alloc_req = 2'b00; free_en = 2'b00;
    chk("fl_busy", busy, 32'h0);
    chk("fl_cnt", 32'(free_cnt), 32'd32);
    chk("fl_err", 32'(err), 32'd1);

    // Reset mid-burst
    alloc_req = 2'b11;
    repeat (3) step();
    chk("burst_cnt", 32'(free_cnt), 32'd26);
    chk("burst_busy", busy, 32'hE000_0007);
    #1;
    reset = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 32'h0);
    chk("mid_rst_cnt", 32'(free_cnt), 32'd32);
    chk("mid_rst_err", 32'(err), 32'd0);
    alloc_req = 2'b00;
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("post_rst_idx1", 32'(grant_idx1), 32'd31);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
